stopwatch_counter: RTL and testbench

Parametrised multi-digit up/down timer for the front-panel display path: divides the system clock by a prescaler and advances a chain of binary-coded digits, each with its own modulus. It adds over the fixed 4-digit 10 Hz stopwatch a configurable digit count and moduli, count-down mode with a terminal-zero stop, preset load, and a display hold (lap) function. Its packed digit bus feeds the seven-segment multiplexer directly.

---
 rtl/stopwatch_counter.sv | 137 +++++++++++++
 tb/tb_stopwatch_counter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// Prescaled multi-digit up/down timer with per-digit moduli, preset load,
// terminal-zero stop in count-down mode and a display hold register.
module stopwatch_counter #(
   parameter int          NUM_DIGITS = 4,
   parameter logic [31:0] DIGIT_MOD  = 32'h0000_A6AA,
   parameter logic [7:0]  DP_MASK    = 8'b0000_1010,
   parameter int          COUNT_MAX  = 10_000_000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    clear,
   input  logic                    dir,
   input  logic                    load,
   input  logic [NUM_DIGITS*4-1:0] load_value,
   input  logic                    hold,
   output logic [NUM_DIGITS*5-1:0] digits,
   output logic                    tick,
   output logic                    wrap,
   output logic                    done,
   output logic                    zero
);

   localparam int            PW   = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
   localparam logic [PW-1:0] TERM = PW'(COUNT_MAX - 1);
   localparam int            CW   = NUM_DIGITS * 4;

   logic [PW-1:0] presc, presc_nxt;
   logic [CW-1:0] cnt, cnt_nxt, up_val, dn_val, ld_val, disp;
   logic          up_carry;
   logic          tick_nxt, wrap_nxt, done_nxt;
   logic          upd;
   logic          term;

   assign term = enable && (presc == TERM);

   // Ripple increment/decrement and load clamp, each nibble in its own modulus.
   always_comb begin : digit_arith
      logic       c;
      logic       b;
      logic [3:0] m;
      logic [3:0] d;
      c      = 1'b1;
      b      = 1'b1;
      m      = '0;
      d      = '0;
      up_val = cnt;
      dn_val = cnt;
      ld_val = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         m = DIGIT_MOD[4*i +: 4];
         d = cnt[4*i +: 4];
         if (c) begin
            if (d == m - 4'd1) begin
               up_val[4*i +: 4] = '0;
            end else begin
               up_val[4*i +: 4] = d + 4'd1;
               c = 1'b0;
            end
         end
         if (b) begin
            if (d == 4'd0) begin
               dn_val[4*i +: 4] = m - 4'd1;
            end else begin
               dn_val[4*i +: 4] = d - 4'd1;
               b = 1'b0;
            end
         end
         ld_val[4*i +: 4] = (load_value[4*i +: 4] > m - 4'd1) ? m - 4'd1
                                                             : load_value[4*i +: 4];
      end
      up_carry = c;
   end

   // clear beats load beats counting; either one swallows a coincident step.
   always_comb begin : next_state
      presc_nxt = presc;
      cnt_nxt   = cnt;
      tick_nxt  = 1'b0;
      wrap_nxt  = 1'b0;
      done_nxt  = 1'b0;
      if (clear) begin
         presc_nxt = '0;
         cnt_nxt   = '0;
      end else if (load) begin
         presc_nxt = '0;
         cnt_nxt   = ld_val;
      end else if (enable) begin
         if (term) begin
            presc_nxt = '0;
            tick_nxt  = 1'b1;
            if (!dir) begin
               cnt_nxt  = up_val;
               wrap_nxt = up_carry;
            end else if (!zero) begin
               cnt_nxt  = dn_val;
               done_nxt = (dn_val == '0);
            end
         end else begin
            presc_nxt = presc + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc <= '0;
         cnt   <= '0;
         disp  <= '0;
         upd   <= 1'b0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
         done  <= 1'b0;
         zero  <= 1'b1;
      end else begin
         presc <= presc_nxt;
         cnt   <= cnt_nxt;
         tick  <= tick_nxt;
         wrap  <= wrap_nxt;
         done  <= done_nxt;
         zero  <= (cnt_nxt == '0);
         upd   <= clear | load;
         // upd lets a clear/load reach the display one cycle later despite hold.
         if (!hold || upd) begin
            disp <= cnt;
         end
      end
   end

   always_comb begin : pack_digits
      digits = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digits[5*i +: 5] = {DP_MASK[i], disp[4*i +: 4]};
      end
   end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: COUNT_MAX=4, default tenths/seconds/ten-seconds/minutes
// moduli, mixed-radix integer reference model feeding an expected-display queue.
module tb_stopwatch_counter;

   localparam int CM    = 4;
   localparam int TOTAL = 6000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic        dir = 1'b0;
   logic        load = 1'b0;
   logic        hold = 1'b0;
   logic [15:0] load_value = '0;
   logic [19:0] digits;
   logic        tick, wrap, done, zero;

   int          total = 0;
   int          bad = 0;
   logic [19:0] exp_q[$];

   int          m_pres, m_val, m_disp;
   bit          m_upd, m_tick, m_wrap, m_done, m_zero;

   stopwatch_counter #(
      .NUM_DIGITS(4),
      .DIGIT_MOD (32'h0000_A6AA),
      .DP_MASK   (8'b0000_1010),
      .COUNT_MAX (CM)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .clear     (clear),
      .dir       (dir),
      .load      (load),
      .load_value(load_value),
      .hold      (hold),
      .digits    (digits),
      .tick      (tick),
      .wrap      (wrap),
      .done      (done),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   // Integer value 0..5999 to the displayed 20-bit word, DP on digits 1 and 3.
   function automatic logic [19:0] to_word(input int v);
      logic [3:0] d0, d1, d2, d3;
      d0 = 4'(v % 10); v = v / 10;
      d1 = 4'(v % 10); v = v / 10;
      d2 = 4'(v % 6);  v = v / 6;
      d3 = 4'(v % 10);
      return {1'b1, d3, 1'b0, d2, 1'b1, d1, 1'b0, d0};
   endfunction

   function automatic int load_to_int(input logic [15:0] lv);
      int d0, d1, d2, d3;
      d0 = (lv[3:0]   > 4'd9) ? 9 : int'(lv[3:0]);
      d1 = (lv[7:4]   > 4'd9) ? 9 : int'(lv[7:4]);
      d2 = (lv[11:8]  > 4'd5) ? 5 : int'(lv[11:8]);
      d3 = (lv[15:12] > 4'd9) ? 9 : int'(lv[15:12]);
      return d0 + 10 * d1 + 100 * d2 + 600 * d3;
   endfunction

   task automatic model_reset();
      m_pres = 0; m_val = 0; m_disp = 0; m_upd = 0;
      m_tick = 0; m_wrap = 0; m_done = 0; m_zero = 1;
      exp_q.delete();
   endtask

   // Advance the reference model by one clock using the driven inputs, queue
   // the expected display, then step the clock and settle past the edge.
   task automatic cycle();
      if (!hold || m_upd) m_disp = m_val;
      m_upd  = clear | load;
      m_tick = 0; m_wrap = 0; m_done = 0;
      if (clear) begin
         m_pres = 0; m_val = 0;
      end else if (load) begin
         m_pres = 0; m_val = load_to_int(load_value);
      end else if (enable) begin
         if (m_pres == CM - 1) begin
            m_pres = 0; m_tick = 1;
            if (!dir) begin
               m_val = (m_val + 1) % TOTAL; m_wrap = (m_val == 0);
            end else if (m_val != 0) begin
               m_val = m_val - 1; m_done = (m_val == 0);
            end
         end else begin
            m_pres = m_pres + 1;
         end
      end
      m_zero = (m_val == 0);
      exp_q.push_back(to_word(m_disp));
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      total++;
      if (digits !== 20'h80200) begin
         bad++; $display("FAIL reset_digits got=%h exp=%h", digits, 20'h80200);
      end
      total++;
      if ({tick, wrap, done, zero} !== 4'b0001) begin
         bad++; $display("FAIL reset_flags got=%b exp=0001", {tick, wrap, done, zero});
      end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
   endtask

   task automatic test_count_up();
      logic [19:0] e;
      int ticks_seen, wraps_seen;
      ticks_seen = 0; wraps_seen = 0;
      enable = 1'b1; dir = 1'b0;
      for (int c = 0; c < TOTAL * CM + 2; c++) begin
         cycle();
         e = exp_q.pop_front();
         total++;
         if (digits !== e) begin
            bad++; $display("FAIL up_digits t=%0t got=%h exp=%h", $time, digits, e);
         end
         total++;
         if ({tick, wrap, done, zero} !== {m_tick, m_wrap, m_done, m_zero}) begin
            bad++; $display("FAIL up_flags t=%0t got=%b exp=%b", $time,
                            {tick, wrap, done, zero}, {m_tick, m_wrap, m_done, m_zero});
         end
         if (tick === 1'b1) ticks_seen++;
         if (wrap === 1'b1) begin
            wraps_seen++;
            total++;
            if (digits !== {1'b1, 4'd9, 1'b0, 4'd5, 1'b1, 4'd9, 1'b0, 4'd9}) begin
               bad++; $display("FAIL up_top_before_wrap got=%h exp=9599", digits);
            end
         end
      end
      total++;
      if (ticks_seen != TOTAL) begin
         bad++; $display("FAIL up_tick_count got=%0d exp=%0d", ticks_seen, TOTAL);
      end
      total++;
      if (wraps_seen != 1) begin
         bad++; $display("FAIL up_wrap_count got=%0d exp=1", wraps_seen);
      end
   endtask

   task automatic test_count_down();
      logic [19:0] e;
      int dones_seen;
      dones_seen = 0;
      dir = 1'b1; load_value = 16'h0012; load = 1'b1;
      cycle();
      load = 1'b0;
      void'(exp_q.pop_front());
      for (int c = 0; c < 14 * CM; c++) begin
         cycle();
         e = exp_q.pop_front();
         total++;
         if (digits !== e) begin
            bad++; $display("FAIL down_digits t=%0t got=%h exp=%h", $time, digits, e);
         end
         total++;
         if ({tick, done, zero} !== {m_tick, m_done, m_zero}) begin
            bad++; $display("FAIL down_flags t=%0t got=%b exp=%b", $time,
                            {tick, done, zero}, {m_tick, m_done, m_zero});
         end
         if (done === 1'b1) dones_seen++;
      end
      total++;
      if (dones_seen != 1) begin
         bad++; $display("FAIL down_done_count got=%0d exp=1", dones_seen);
      end
      total++;
      if (digits !== 20'h80200 || zero !== 1'b1) begin
         bad++; $display("FAIL down_stop got=%h/%b exp=80200/1", digits, zero);
      end
   endtask

   task automatic test_borrow();
      logic [19:0] e;
      dir = 1'b1; load_value = 16'h1000; load = 1'b1;
      cycle();
      load = 1'b0;
      void'(exp_q.pop_front());
      for (int c = 0; c < CM + 1; c++) begin
         cycle();
         e = exp_q.pop_front();
         total++;
         if (digits !== e) begin
            bad++; $display("FAIL borrow_digits t=%0t got=%h exp=%h", $time, digits, e);
         end
      end
      total++;
      if (digits !== {1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd9, 1'b0, 4'd9}) begin
         bad++; $display("FAIL borrow_result got=%h exp=0599", digits);
      end
   endtask

   task automatic test_hold();
      logic [19:0] e;
      dir = 1'b0; load_value = 16'h0003; load = 1'b1;
      cycle();
      load = 1'b0;
      void'(exp_q.pop_front());
      cycle();
      void'(exp_q.pop_front());
      hold = 1'b1;
      for (int c = 0; c < 5 * CM; c++) begin
         cycle();
         e = exp_q.pop_front();
         total++;
         if (digits !== e || digits !== {1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd3}) begin
            bad++; $display("FAIL hold_frozen t=%0t got=%h exp=%h", $time, digits, e);
         end
      end
      hold = 1'b0;
      cycle();
      e = exp_q.pop_front();
      total++;
      if (digits !== e || digits !== {1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd8}) begin
         bad++; $display("FAIL hold_release got=%h exp=%h", digits, e);
      end
   endtask

   task automatic test_priority();
      logic [19:0] e;
      dir = 1'b0;
      for (int c = 0; c < 2 * CM && m_pres != CM - 1; c++) begin
         cycle();
         void'(exp_q.pop_front());
      end
      clear = 1'b1; load = 1'b1; load_value = 16'h0005;
      cycle();
      clear = 1'b0; load = 1'b0;
      void'(exp_q.pop_front());
      total++;
      if ({tick, wrap, done} !== 3'b000) begin
         bad++; $display("FAIL prio_flags got=%b exp=000", {tick, wrap, done});
      end
      cycle();
      e = exp_q.pop_front();
      total++;
      if (digits !== e || digits !== 20'h80200) begin
         bad++; $display("FAIL prio_clear got=%h exp=%h", digits, e);
      end
      enable = 1'b0; load_value = 16'h0F00; load = 1'b1;
      cycle();
      load = 1'b0;
      void'(exp_q.pop_front());
      cycle();
      e = exp_q.pop_front();
      total++;
      if (digits !== e || digits !== {1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0}) begin
         bad++; $display("FAIL prio_clamp got=%h exp=%h", digits, e);
      end
      hold = 1'b1; load_value = 16'hFFFF; load = 1'b1;
      cycle();
      load = 1'b0;
      void'(exp_q.pop_front());
      cycle();
      e = exp_q.pop_front();
      total++;
      if (digits !== e || digits !== {1'b1, 4'd9, 1'b0, 4'd5, 1'b1, 4'd9, 1'b0, 4'd9}) begin
         bad++; $display("FAIL prio_load_hold got=%h exp=%h", digits, e);
      end
      hold = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [19:0] e;
      enable = 1'b1; dir = 1'b0;
      for (int c = 0; c < 2 * CM + 2; c++) begin
         cycle();
         e = exp_q.pop_front();
         total++;
         if (digits !== e || wrap !== m_wrap) begin
            bad++; $display("FAIL pre_reset t=%0t got=%h/%b exp=%h/%b", $time, digits, wrap, e, m_wrap);
         end
      end
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (digits !== 20'h80200 || {tick, wrap, done, zero} !== 4'b0001) begin
         bad++; $display("FAIL async_reset got=%h/%b exp=80200/0001", digits, {tick, wrap, done, zero});
      end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      for (int c = 0; c < CM + 1; c++) begin
         cycle();
         e = exp_q.pop_front();
         total++;
         if (digits !== e || tick !== m_tick) begin
            bad++; $display("FAIL post_reset t=%0t got=%h/%b exp=%h/%b", $time, digits, tick, e, m_tick);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_count_up();
      test_count_down();
      test_borrow();
      test_hold();
      test_priority();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
